// File: rtl/key_matrix_scanner_pkg.sv
// Shared keyboard constants: scanner FSM encoding and event word layout.
// The event FIFO block uses the same event constants.
package key_matrix_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_EMIT,
        ST_GAP,
        ST_NEXT
    } scanState_t;

    localparam int KMS_ROWS           = 4;
    localparam int KMS_COLS           = 4;
    localparam int KMS_EVENT_WIDTH    = 8;
    localparam int KMS_SETTLE_CYCLES  = 4;
    localparam int KMS_DEBOUNCE_SCANS = 3;
    localparam int KMS_CNT_WIDTH      = 2;

    // Event word: press flag on top, key index row*COLS+col below it.
    localparam int EV_PRESS_BIT = KMS_EVENT_WIDTH - 1;
    localparam int EV_KEY_W     = KMS_EVENT_WIDTH - 1;

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Matrix pins and event-port bundle between the scanner and its neighbours.
interface key_matrix_scanner_if
    import key_matrix_scanner_pkg::*;
#(
    parameter int ROWS        = KMS_ROWS,
    parameter int COLS        = KMS_COLS,
    parameter int EVENT_WIDTH = KMS_EVENT_WIDTH
);
    logic                   En;
    logic [ROWS-1:0]        RowDrv;
    logic [COLS-1:0]        ColSense;
    logic [EVENT_WIDTH-1:0] EvData;
    logic                   EvWr;
    logic                   AnyPressed;

    modport master (
        input  En, ColSense,
        output RowDrv, EvData, EvWr, AnyPressed
    );

    modport slave (
        output En, ColSense,
        input  RowDrv, EvData, EvWr, AnyPressed
    );
endinterface

// File: rtl/key_col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low column inputs.
module key_col_sync
    import key_matrix_scanner_pkg::*;
#(
    parameter int COLS = KMS_COLS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] colAsync,
    output logic [COLS-1:0] colSync
);
    logic [COLS-1:0] colMeta_p0;
    logic [COLS-1:0] colSync_p1;

    // Reset to all-ones so no key looks pressed while the chain refills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colMeta_p0 <= '1;
            colSync_p1 <= '1;
        end else begin
            colMeta_p0 <= colAsync;
            colSync_p1 <= colMeta_p0;
        end
    end

    assign colSync = colSync_p1;
endmodule

// File: rtl/key_matrix_scanner.sv
// Row-by-row matrix scanner with per-key debounce; each accepted change becomes
// one event word followed by an isolated single-cycle write strobe.
module key_matrix_scanner
    import key_matrix_scanner_pkg::*;
#(
    parameter int ROWS           = KMS_ROWS,
    parameter int COLS           = KMS_COLS,
    parameter int EVENT_WIDTH    = KMS_EVENT_WIDTH,
    parameter int SETTLE_CYCLES  = KMS_SETTLE_CYCLES,
    parameter int DEBOUNCE_SCANS = KMS_DEBOUNCE_SCANS,
    parameter int CNT_WIDTH      = KMS_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    key_matrix_scanner_if.master kbd
);
    localparam int NKEYS  = ROWS * COLS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KSEL_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES);
    localparam int KEY_W  = EVENT_WIDTH - 1;
    localparam logic [CNT_WIDTH:0] DEB_TARGET = (CNT_WIDTH+1)'(DEBOUNCE_SCANS);

    scanState_t             state, nextState;
    logic [ROW_W-1:0]       rowIdx, rowNext;
    logic [COL_W-1:0]       colIdx;
    logic [SET_W-1:0]       settleCnt;
    logic [COLS-1:0]        colSync, colSnap;
    logic [NKEYS-1:0]       keyState;
    logic [CNT_WIDTH-1:0]   cnt [NKEYS];
    logic [KSEL_W-1:0]      keySel;
    logic [ROWS-1:0]        rowDrvNext;
    logic                   raw, differ, hit, lastCol;

    key_col_sync #(.COLS(COLS)) uColSync (
        .clk      (clk),
        .rst      (rst),
        .colAsync (kbd.ColSense),
        .colSync  (colSync)
    );

    assign keySel  = KSEL_W'(int'(rowIdx) * COLS + int'(colIdx));
    assign raw     = ~colSnap[colIdx];
    assign differ  = (raw != keyState[keySel]);
    assign hit     = differ && (({1'b0, cnt[keySel]} + (CNT_WIDTH+1)'(1)) == DEB_TARGET);
    assign lastCol = (colIdx == COL_W'(COLS - 1));
    assign rowNext = (rowIdx == ROW_W'(ROWS - 1)) ? '0 : rowIdx + ROW_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState  = state;
        rowDrvNext = kbd.RowDrv;
        unique case (state)
            ST_IDLE: begin
                if (kbd.En) begin
                    nextState  = ST_SETTLE;
                    rowDrvNext = ~(ROWS'(1) << rowIdx);
                end
            end
            ST_SETTLE: if (settleCnt == SET_W'(SETTLE_CYCLES - 1)) nextState = ST_SAMPLE;
            ST_SAMPLE: nextState = ST_CHECK;
            ST_CHECK: begin
                if (hit)          nextState = ST_EMIT;
                else if (lastCol) nextState = ST_NEXT;
            end
            ST_EMIT: nextState = ST_GAP;
            ST_GAP:  nextState = lastCol ? ST_NEXT : ST_CHECK;
            ST_NEXT: begin
                nextState  = kbd.En ? ST_SETTLE : ST_IDLE;
                rowDrvNext = kbd.En ? ~(ROWS'(1) << rowNext) : '1;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // EvWr is registered from the EMIT state, so EvData (loaded leaving CHECK)
    // is already stable for a full clock when the strobe rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowIdx         <= '0;
            colIdx         <= '0;
            settleCnt      <= '0;
            keyState       <= '0;
            kbd.RowDrv     <= '1;
            kbd.EvData     <= '0;
            kbd.EvWr       <= 1'b0;
            kbd.AnyPressed <= 1'b0;
            for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else begin
            kbd.RowDrv     <= rowDrvNext;
            kbd.EvWr       <= (state == ST_EMIT);
            kbd.AnyPressed <= |keyState;
            unique case (state)
                ST_IDLE:   settleCnt <= '0;
                ST_SETTLE: settleCnt <= settleCnt + SET_W'(1);
                ST_SAMPLE: colIdx <= '0;
                ST_CHECK: begin
                    if (!differ) begin
                        cnt[keySel] <= '0;
                    end else if (hit) begin
                        keyState[keySel] <= raw;
                        cnt[keySel]      <= '0;
                        kbd.EvData       <= {raw, KEY_W'(keySel)};
                    end else begin
                        cnt[keySel] <= cnt[keySel] + CNT_WIDTH'(1);
                    end
                    if (!hit && !lastCol) colIdx <= colIdx + COL_W'(1);
                end
                ST_GAP: if (!lastCol) colIdx <= colIdx + COL_W'(1);
                ST_NEXT: begin
                    rowIdx    <= rowNext;
                    settleCnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_SAMPLE) colSnap <= colSync;
    end
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: simulated key matrix, a row-schedule reference
// model checked every cycle, and directed plus random key activity.
module tb_key_matrix_scanner;
    import key_matrix_scanner_pkg::*;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int EVW    = 8;
    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int NKEYS  = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .EVENT_WIDTH(EVW)) kif();

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .EVENT_WIDTH(EVW),
        .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB), .CNT_WIDTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kif)
    );

    // Physical matrix: a pressed key shorts its row to its column.
    bit keys [ROWS][COLS];
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            kif.ColSense[c] = 1'b1;
            for (int r = 0; r < ROWS; r++)
                if (!kif.RowDrv[r] && keys[r][c]) kif.ColSense[c] = 1'b0;
        end
    end

    typedef struct packed {
        logic [ROWS-1:0] drv;
        logic            wr;
        logic [EVW-1:0]  ev;
        logic            any;
    } exp_t;

    exp_t           expQ[$];
    exp_t           expCur, actCur;
    bit             mState [NKEYS];
    int             mCnt   [NKEYS];
    int             mRow;
    logic [EVW-1:0] mEv;
    logic           mAny;
    logic [EVW-1:0] evLog[$];
    int             total = 0;
    int             bad   = 0;
    bit             chkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [EVW-1:0] lastEv(input int back);
        if (evLog.size() > back) return evLog[evLog.size() - 1 - back];
        return 'x;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < NKEYS; k++) begin
            mState[k] = 1'b0;
            mCnt[k]   = 0;
        end
        mRow = 0;
        mEv  = '0;
        mAny = 1'b0;
    endfunction

    function automatic void pushExp(input logic [ROWS-1:0] d, input logic w);
        exp_t e;
        e.drv = d;
        e.wr  = w;
        e.ev  = mEv;
        e.any = mAny;
        expQ.push_back(e);
    endfunction

    // Expected outputs for one whole row visit; returns its length in clocks and
    // the 1-based offset of the first strobe cycle (0 if the row has no event).
    function automatic int pushRow(output int gapOff);
        logic [ROWS-1:0] drv;
        int n, k;
        bit raw;
        drv    = ~(ROWS'(1) << mRow);
        n      = 0;
        gapOff = 0;
        for (int i = 0; i < SETTLE + 1; i++) begin
            pushExp(drv, 1'b0); n++;
        end
        for (int c = 0; c < COLS; c++) begin
            k   = mRow * COLS + c;
            raw = keys[mRow][c];
            pushExp(drv, 1'b0); n++;
            if (raw == mState[k]) begin
                mCnt[k] = 0;
            end else if (mCnt[k] + 1 == DEB) begin
                mState[k] = raw;
                mCnt[k]   = 0;
                mEv       = '0;
                mEv[EV_PRESS_BIT] = raw;
                mEv[EV_PRESS_BIT-1:0] = k[EV_PRESS_BIT-1:0];
                pushExp(drv, 1'b0); n++;
                mAny = 1'b0;
                for (int j = 0; j < NKEYS; j++) mAny = mAny | mState[j];
                pushExp(drv, 1'b1); n++;
                if (gapOff == 0) gapOff = n;
            end else begin
                mCnt[k]++;
            end
        end
        pushExp(drv, 1'b0); n++;
        mRow = (mRow + 1) % ROWS;
        return n;
    endfunction

    // Every cycle with checking enabled is one comparison against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL model queue empty at t=%0t", $time);
            end else begin
                expCur = expQ.pop_front();
                actCur = '{kif.RowDrv, kif.EvWr, kif.EvData, kif.AnyPressed};
                if (actCur !== expCur) begin
                    bad++;
                    $display("FAIL cycle t=%0t: got drv=%b wr=%b ev=%h any=%b want drv=%b wr=%b ev=%h any=%b",
                             $time, actCur.drv, actCur.wr, actCur.ev, actCur.any,
                             expCur.drv, expCur.wr, expCur.ev, expCur.any);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && kif.EvWr === 1'b1) evLog.push_back(kif.EvData);
    end

    // Called on a negedge: release reset with En high.
    task automatic applyRelease();
        rst = 1'b0;
        modelReset();
        kif.En = 1'b1;
        #1 chkEn = 1'b1;
    endtask

    task automatic doRow(input int dropAt, output int len);
        int g;
        len = pushRow(g);
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (i == dropAt) kif.En = 1'b0;
        end
    endtask

    task automatic step(input int n);
        int len;
        repeat (n) doRow(0, len);
    endtask

    task automatic doIdle(input int n);
        kif.En = 1'b0;
        repeat (n) pushExp('1, 1'b0);
        repeat (n) @(negedge clk);
        kif.En = 1'b1;
    endtask

    task automatic rstDuringStrobe();
        int g, len;
        bit found;
        found = 1'b0;
        for (int r = 0; r < 3 * ROWS && !found; r++) begin
            len = pushRow(g);
            if (g > 0) begin
                repeat (g) @(negedge clk);
                check("strobe before reset", kif.EvWr, 1);
                #2;
                chkEn = 1'b0;
                expQ.delete();
                rst = 1'b1;
                #1;
                check("reset EvWr", kif.EvWr, 0);
                check("reset RowDrv", kif.RowDrv, 4'b1111);
                check("reset EvData", kif.EvData, 0);
                check("reset AnyPressed", kif.AnyPressed, 0);
                repeat (2) @(negedge clk);
                applyRelease();
                found = 1'b1;
            end else begin
                repeat (len) @(negedge clk);
            end
        end
        check("reset target event seen", found, 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lens [12];
        int len, evCnt;
        kif.En = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("init RowDrv", kif.RowDrv, 4'b1111);
        check("init EvWr", kif.EvWr, 0);
        check("init EvData", kif.EvData, 0);
        check("init AnyPressed", kif.AnyPressed, 0);
        applyRelease();

        // Single press then release of row1/col2.
        keys[1][2] = 1'b1;
        step(12);
        check("press count", evLog.size(), 1);
        check("press 1,2", lastEv(0), 8'h86);
        check("any after press", kif.AnyPressed, 1);
        keys[1][2] = 1'b0;
        step(12);
        check("release count", evLog.size(), 2);
        check("release 1,2", lastEv(0), 8'h06);
        check("any after release", kif.AnyPressed, 0);

        // Bounce shorter than the debounce window, then a real press.
        keys[0][0] = 1'b1;
        step(8);
        keys[0][0] = 1'b0;
        step(4);
        check("bounce silent", evLog.size(), 2);
        keys[0][0] = 1'b1;
        step(12);
        check("press after bounce count", evLog.size(), 3);
        check("press 0,0", lastEv(0), 8'h80);
        keys[0][0] = 1'b0;
        step(12);
        check("release 0,0", lastEv(0), 8'h00);

        // Two keys in one row: ordered events and a stretched row.
        keys[0][1] = 1'b1;
        keys[0][3] = 1'b1;
        for (int r = 0; r < 12; r++) doRow(0, lens[r]);
        check("plain row period", lens[0], 10);
        check("two-event row period", lens[8], 14);
        check("first of pair", lastEv(1), 8'h81);
        check("second of pair", lastEv(0), 8'h83);

        // Reset while a strobe is high; held keys are reported again.
        keys[2][0] = 1'b1;
        rstDuringStrobe();
        step(12);
        check("re-report a", lastEv(2), 8'h81);
        check("re-report b", lastEv(1), 8'h83);
        check("re-report c", lastEv(0), 8'h88);

        // En dropped mid-row: the row finishes with its events, then idles.
        keys[0][1] = 1'b0;
        keys[0][3] = 1'b0;
        step(8);
        evCnt = evLog.size();
        doRow(3, len);
        check("events in finishing row", evLog.size() - evCnt, 2);
        check("release 0,3", lastEv(0), 8'h03);
        doIdle(6);
        check("idle RowDrv", kif.RowDrv, 4'b1111);
        step(1);
        check("restart at row 1", kif.RowDrv, 4'b1101);

        // Random key activity with occasional scan pauses.
        for (int r = 0; r < 80; r++) begin
            for (int rr = 0; rr < ROWS; rr++)
                for (int c = 0; c < COLS; c++)
                    if ($urandom_range(0, 24) == 0) keys[rr][c] = !keys[rr][c];
            if ($urandom_range(0, 9) == 0) begin
                doRow($urandom_range(1, 8), len);
                doIdle($urandom_range(1, 4));
            end else begin
                doRow(0, len);
            end
        end

        #1;
        chkEn = 1'b0;
        check("model queue drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
